serial_divisibility_by_n_using_fsm: RTL



---
 rtl/serial_divisibility_by_n_using_fsm.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_divisibility_by_n_using_fsm.sv
// ============================================================================
// serial_divisibility_by_n_using_fsm
//
// Purpose:
//   Serial divisibility tester for a compile-time divisor. One bit of a binary
//   number arrives per valid cycle. The block keeps the remainder of the value
//   received so far modulo DIVISOR. The bit order (MSB-first or LSB-first) is
//   chosen each time a new number starts.
//
// Parameters:
//   DIVISOR  modulus N, legal range 2..255
//   CNT_W    width of the saturating received-bit counter
//   REM_W    derived, $clog2(DIVISOR); width of remainder and weight
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset, has priority over everything
//   start_i      begin a new number (may coincide with bit_valid_i)
//   bit_valid_i  new_bit_i is consumed this cycle
//   new_bit_i    next bit of the number
//   lsb_first_i  bit order of the new number, sampled only when start_i is high
//   div_by_n_o   1 when the current remainder is zero
//   remainder_o  current value mod DIVISOR
//   bit_count_o  bits consumed since last start/reset, saturating
//   active_o     at least one bit consumed since last start/reset
// ============================================================================
module serial_divisibility_by_n_using_fsm #(
    parameter int DIVISOR = 7,
    parameter int CNT_W   = 8,
    localparam int REM_W  = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             new_bit_i,
    input  logic             lsb_first_i,
    output logic             div_by_n_o,
    output logic [REM_W-1:0] remainder_o,
    output logic [CNT_W-1:0] bit_count_o,
    output logic             active_o
);

    // Reject divisors outside the supported range while elaborating.
    if (DIVISOR < 2 || DIVISOR > 255) begin : gBadDivisor
        $error("serial_divisibility_by_n_using_fsm: DIVISOR must be in 2..255");
    end
    if (CNT_W < 1) begin : gBadCntW
        $error("serial_divisibility_by_n_using_fsm: CNT_W must be at least 1");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [REM_W:0]   N_EXT     = (REM_W + 1)'(DIVISOR);
    localparam logic [REM_W-1:0] WEIGHT_1  = REM_W'(1);
    localparam logic [CNT_W-1:0] COUNT_MAX = '1;

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [REM_W-1:0] weight_q, weight_d;
    logic             lsbMode_q, lsbMode_d;
    logic [CNT_W-1:0] bitCount_q, bitCount_d;
    logic             divByN_q, divByN_d;

    // Values to absorb the incoming bit into: either the held state, or the
    // freshly cleared state when this cycle also starts a new number.
    logic [REM_W-1:0] baseRem;
    logic [REM_W-1:0] baseWeight;
    logic             baseMode;
    logic [CNT_W-1:0] baseCount;
    logic [REM_W:0]   remSum;
    logic [REM_W:0]   weightSum;

    // Every operand is below N, so any sum of two of them is below 2N and a
    // single conditional subtract brings it back into range.
    function automatic logic [REM_W-1:0] modReduce(input logic [REM_W:0] x);
        logic [REM_W:0] diff;
        diff = x - N_EXT;
        return (x >= N_EXT) ? diff[REM_W-1:0] : x[REM_W-1:0];
    endfunction

    // Next-state logic: clear on start, then optionally absorb one bit under
    // the mode in force (a start cycle uses the mode it has just sampled).
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        weight_d   = weight_q;
        lsbMode_d  = lsbMode_q;
        bitCount_d = bitCount_q;
        baseRem    = rem_q;
        baseWeight = weight_q;
        baseMode   = lsbMode_q;
        baseCount  = bitCount_q;
        remSum     = '0;
        weightSum  = '0;

        if (start_i) begin
            baseRem    = '0;
            baseWeight = WEIGHT_1;
            baseMode   = lsb_first_i;
            baseCount  = '0;
            rem_d      = '0;
            weight_d   = WEIGHT_1;
            lsbMode_d  = lsb_first_i;
            bitCount_d = '0;
            state_d    = EMPTY;
        end

        if (bit_valid_i) begin
            if (baseMode) begin
                remSum    = {1'b0, baseRem} + (new_bit_i ? {1'b0, baseWeight} : '0);
                weightSum = {baseWeight, 1'b0};
                weight_d  = modReduce(weightSum);
            end else begin
                remSum    = {baseRem, new_bit_i};
            end
            rem_d      = modReduce(remSum);
            bitCount_d = (baseCount == COUNT_MAX) ? baseCount : baseCount + 1'b1;
            state_d    = ACCUM;
        end

        divByN_d = (rem_d == '0);
    end

    // State register; reset returns to an empty MSB-first number whose value
    // is zero, so div_by_n reads as 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            rem_q      <= '0;
            weight_q   <= WEIGHT_1;
            lsbMode_q  <= 1'b0;
            bitCount_q <= '0;
            divByN_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            weight_q   <= weight_d;
            lsbMode_q  <= lsbMode_d;
            bitCount_q <= bitCount_d;
            divByN_q   <= divByN_d;
        end
    end

    assign div_by_n_o  = divByN_q;
    assign remainder_o = rem_q;
    assign bit_count_o = bitCount_q;
    assign active_o    = (state_q == ACCUM);

endmodule
